// File: rtl/post_spike_aer_encoder_if.sv
// Event-in / AER-out bundle for post_spike_aer_encoder.
// master: the encoder; slave: the neuron controller and the off-core AER receiver.
interface post_spike_aer_encoder_if #(
    parameter int unsigned POST_NEUR_PARALLEL   = 4,
    parameter int unsigned POST_NEUR_ADDR_WIDTH = 10,
    parameter int unsigned AER_WIDTH            = 12,
    parameter int unsigned TIME_STEP            = 8,
    parameter int unsigned FIFO_DEPTH           = 16
);
    localparam int unsigned IDX_W = $clog2(POST_NEUR_PARALLEL);
    localparam int unsigned GRP_W = POST_NEUR_ADDR_WIDTH - IDX_W;
    localparam int unsigned TS_W  = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [POST_NEUR_PARALLEL-1:0] NEUR_EVENT_OUT;
    logic                          EVT_VALID;
    logic [GRP_W-1:0]              EVT_GROUP_ADDR;
    logic [TS_W-1:0]               CURRENT_TIME_STEP;
    logic                          EVT_READY;
    logic                          CLR_DROP;
    logic                          EVT_DROP;
    logic [LVL_W-1:0]              FIFO_LEVEL;
    logic [AER_WIDTH-1:0]          AEROUT_ADDR;
    logic                          AEROUT_REQ;
    logic                          AEROUT_ACK;

    modport master (
        input  NEUR_EVENT_OUT, EVT_VALID, EVT_GROUP_ADDR, CURRENT_TIME_STEP,
               CLR_DROP, AEROUT_ACK,
        output EVT_READY, EVT_DROP, FIFO_LEVEL, AEROUT_ADDR, AEROUT_REQ
    );

    modport slave (
        output NEUR_EVENT_OUT, EVT_VALID, EVT_GROUP_ADDR, CURRENT_TIME_STEP,
               CLR_DROP, AEROUT_ACK,
        input  EVT_READY, EVT_DROP, FIFO_LEVEL, AEROUT_ADDR, AEROUT_REQ
    );
endinterface

// File: rtl/post_spike_aer_encoder.sv
// Serialises post-synaptic spike vectors into neuron addresses, buffers them and
// sends them over a four-phase AER link. Optional macro AER_TSTEP_TAG_EN tags words with the time step.
module post_spike_aer_encoder #(
    parameter int unsigned POST_NEUR_PARALLEL   = 4,
    parameter int unsigned POST_NEUR_ADDR_WIDTH = 10,
    parameter int unsigned AER_WIDTH            = 12,
    parameter int unsigned TIME_STEP            = 8,
    parameter int unsigned FIFO_DEPTH           = 16
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    post_spike_aer_encoder_if.master  bus
);
    localparam int unsigned IDX_W = $clog2(POST_NEUR_PARALLEL);
    localparam int unsigned GRP_W = POST_NEUR_ADDR_WIDTH - IDX_W;
    localparam int unsigned TS_W  = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
`ifdef AER_TSTEP_TAG_EN
    localparam int unsigned ENT_W = TS_W + POST_NEUR_ADDR_WIDTH;
`else
    localparam int unsigned ENT_W = POST_NEUR_ADDR_WIDTH;
`endif

    generate
        if (ENT_W > AER_WIDTH) begin : g_aer_width_err
            $error("AER_WIDTH too narrow for the FIFO entry");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_ACKLO
    } state_t;

    state_t                        state;
    logic [POST_NEUR_PARALLEL-1:0] pend_mask;
    logic [GRP_W-1:0]              grp_q;
    logic [ENT_W-1:0]              mem [FIFO_DEPTH];
    logic [PTR_W-1:0]              wr_ptr;
    logic [PTR_W-1:0]              rd_ptr;
    logic [LVL_W-1:0]              level;
    logic                          ack_meta;
    logic                          ack_s;
    logic                          drop_q;
    logic                          req_q;
    logic [AER_WIDTH-1:0]          addr_q;

    logic                          ready_c;
    logic                          accept_c;
    logic                          full_c;
    logic                          empty_c;
    logic                          push_c;
    logic                          pop_c;
    logic [IDX_W-1:0]              low_idx_c;
    logic [ENT_W-1:0]              push_ent_c;

`ifdef AER_TSTEP_TAG_EN
    logic [TS_W-1:0]               ts_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ts_q <= '0;
        end else if (accept_c) begin
            ts_q <= bus.CURRENT_TIME_STEP;
        end
    end

    assign push_ent_c = {ts_q, grp_q, low_idx_c};
`else
    logic unused_ts_c;
    assign unused_ts_c = ^bus.CURRENT_TIME_STEP;
    assign push_ent_c  = {grp_q, low_idx_c};
`endif

    assign ready_c  = (pend_mask == '0);
    assign accept_c = bus.EVT_VALID & ready_c;
    // Full test uses the pre-edge level, so a same-edge pop never frees a slot for a push.
    assign full_c   = (level == LVL_W'(FIFO_DEPTH));
    assign empty_c  = (level == '0);
    assign push_c   = (pend_mask != '0) & ~full_c;
    assign pop_c    = (state == S_REQ) & ack_s;

    // Lowest set bit of the pending mask; scanning downward lets the lowest index win.
    always_comb begin
        low_idx_c = '0;
        for (int i = POST_NEUR_PARALLEL - 1; i >= 0; i--) begin
            if (pend_mask[i]) begin
                low_idx_c = IDX_W'(i);
            end
        end
    end

    // Capture a vector when idle, otherwise retire one pending bit per push.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_mask <= '0;
            grp_q     <= '0;
        end else if (accept_c) begin
            pend_mask <= bus.NEUR_EVENT_OUT;
            grp_q     <= bus.EVT_GROUP_ADDR;
        end else if (push_c) begin
            pend_mask <= pend_mask & (pend_mask - POST_NEUR_PARALLEL'(1));
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            drop_q <= 1'b0;
        end else if (bus.EVT_VALID && !ready_c) begin
            drop_q <= 1'b1;
        end else if (bus.CLR_DROP) begin
            drop_q <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= bus.AEROUT_ACK;
            ack_s    <= ack_meta;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level + LVL_W'(push_c) - LVL_W'(pop_c);
        end
    end

    // Storage is not reset; the reset pointers and level make old contents unreachable.
    always_ff @(posedge CLK) begin
        if (push_c) begin
            mem[wr_ptr] <= push_ent_c;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= S_IDLE;
            req_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty_c) begin
                        addr_q <= AER_WIDTH'(mem[rd_ptr]);
                        req_q  <= 1'b1;
                        state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ack_s) begin
                        req_q <= 1'b0;
                        state <= S_ACKLO;
                    end
                end
                S_ACKLO: begin
                    if (!ack_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    req_q <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.EVT_READY   = ready_c;
    assign bus.EVT_DROP    = drop_q;
    assign bus.FIFO_LEVEL  = level;
    assign bus.AEROUT_ADDR = addr_q;
    assign bus.AEROUT_REQ  = req_q;

endmodule

// File: tb/tb_post_spike_aer_encoder.sv
// Self-checking bench for post_spike_aer_encoder: directed table, corner sequences,
// and randomized vectors scored against an address-list model.
module tb_post_spike_aer_encoder;
    localparam int unsigned P  = 4;
    localparam int unsigned NA = 10;
    localparam int unsigned TS = 8;
    localparam int unsigned FD = 16;
`ifdef AER_TSTEP_TAG_EN
    localparam int unsigned AW      = 13;
    localparam int unsigned EXP_TAG = (6 << 10) | 11;
`else
    localparam int unsigned AW      = 12;
    localparam int unsigned EXP_TAG = 11;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    post_spike_aer_encoder_if #(
        .POST_NEUR_PARALLEL(P), .POST_NEUR_ADDR_WIDTH(NA), .AER_WIDTH(AW),
        .TIME_STEP(TS), .FIFO_DEPTH(FD)
    ) bus ();

    post_spike_aer_encoder #(
        .POST_NEUR_PARALLEL(P), .POST_NEUR_ADDR_WIDTH(NA), .AER_WIDTH(AW),
        .TIME_STEP(TS), .FIFO_DEPTH(FD)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int grp;
        int vec;
        int ts;
        int exp_low;
    } row_t;

    int          n_vec = 0;
    int          n_bad = 0;
    int unsigned exp_q[$];
    int          n_words = 0;
    bit          hold = 1'b0;
    bit          rand_dly = 1'b0;
    int          ack_dly = 2;
    int          r_st = 0;
    int          r_cnt = 0;
    int          r_to = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: every accepted vector yields its set bits as addresses, lowest neuron first.
    task automatic model_push(input int g, input int v, input int ts);
        int unsigned tag;
`ifdef AER_TSTEP_TAG_EN
        tag = ts << NA;
`else
        tag = 0;
`endif
        for (int i = 0; i < P; i++) begin
            if (v[i]) exp_q.push_back(tag + g * P + i);
        end
    endtask

    // AER receiver: checks each requested word, then completes the four-phase handshake.
    always @(negedge clk) begin
        int unsigned exp_w;
        if (!rst_n) begin
            bus.AEROUT_ACK = 1'b0;
            r_st = 0;
        end else begin
            case (r_st)
                0: if (bus.AEROUT_REQ && !hold) begin
                    exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                    chk("aer_word", 32'(bus.AEROUT_ADDR), exp_w);
                    n_words++;
                    r_cnt = rand_dly ? int'($urandom_range(0, 3)) : ack_dly;
                    r_st = 1;
                end
                1: if (r_cnt == 0) begin
                    bus.AEROUT_ACK = 1'b1;
                    r_to = 0;
                    r_st = 2;
                end else begin
                    r_cnt--;
                end
                2: if (!bus.AEROUT_REQ) begin
                    bus.AEROUT_ACK = 1'b0;
                    r_st = 0;
                end else begin
                    r_to++;
                    if (r_to > 40) begin
                        chk("req_fall_timeout", 32'(bus.AEROUT_REQ), 0);
                        bus.AEROUT_ACK = 1'b0;
                        r_st = 0;
                    end
                end
                default: r_st = 0;
            endcase
        end
    end

    // Called at a negedge; returns at the negedge after the capture edge.
    task automatic send_vec(input int g, input int v, input int ts);
        int t = 0;
        while (!bus.EVT_READY && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            chk("ready_wait_timeout", 32'(bus.EVT_READY), 1);
        end else begin
            bus.EVT_VALID         = 1'b1;
            bus.EVT_GROUP_ADDR    = 8'(g);
            bus.NEUR_EVENT_OUT    = 4'(v);
            bus.CURRENT_TIME_STEP = 3'(ts);
            model_push(g, v, ts);
            @(negedge clk);
            bus.EVT_VALID = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || bus.AEROUT_REQ || r_st != 0 || bus.FIFO_LEVEL != 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk("drain_timeout", 32'(exp_q.size()), 0);
        repeat (6) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(bus.EVT_READY), 1);
        chk({tag, "_req"},   32'(bus.AEROUT_REQ), 0);
        chk({tag, "_addr"},  32'(bus.AEROUT_ADDR), 0);
        chk({tag, "_level"}, 32'(bus.FIFO_LEVEL), 0);
        chk({tag, "_drop"},  32'(bus.EVT_DROP), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d words seen", n_words);
        $fatal(1, "watchdog");
    end

    initial begin
        row_t rows[7];
        int   low;
        int   w0;
        rows[0] = '{5,   10, 0, 2};
        rows[1] = '{0,   15, 1, 4};
        rows[2] = '{63,   9, 2, 2};
        rows[3] = '{7,    0, 3, 0};
        rows[4] = '{1,    1, 4, 1};
        rows[5] = '{255,  8, 7, 1};
        rows[6] = '{128,  6, 5, 2};

        rst_n                 = 1'b0;
        bus.EVT_VALID         = 1'b0;
        bus.NEUR_EVENT_OUT    = '0;
        bus.EVT_GROUP_ADDR    = '0;
        bus.CURRENT_TIME_STEP = '0;
        bus.CLR_DROP          = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset_start");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table; rows 1 and 2 run back-to-back at the earliest ready.
        ack_dly = 2;
        for (int r = 0; r < 7; r++) begin
            send_vec(rows[r].grp, rows[r].vec, rows[r].ts);
            low = 0;
            while (!bus.EVT_READY && low < 64) begin
                low++;
                @(negedge clk);
            end
            chk($sformatf("ready_low_row%0d", r), 32'(low), 32'(rows[r].exp_low));
        end
        drain();

        // Time-step tag word.
        send_vec(2, 8, 6);
        drain();
        chk("tag_addr", 32'(bus.AEROUT_ADDR), EXP_TAG);

        // Violations: ignored vectors, sticky flag, set beats clear.
        w0 = n_words;
        send_vec(9, 15, 0);
        bus.EVT_VALID = 1'b1; bus.EVT_GROUP_ADDR = 8'd20; bus.NEUR_EVENT_OUT = 4'b0101;
        @(negedge clk);
        bus.EVT_VALID = 1'b0;
        chk("drop_set", 32'(bus.EVT_DROP), 1);
        repeat (3) @(negedge clk);
        bus.CLR_DROP = 1'b1;
        @(negedge clk);
        bus.CLR_DROP = 1'b0;
        chk("drop_clear", 32'(bus.EVT_DROP), 0);
        send_vec(11, 7, 0);
        bus.EVT_VALID = 1'b1; bus.CLR_DROP = 1'b1; bus.EVT_GROUP_ADDR = 8'd30; bus.NEUR_EVENT_OUT = 4'b1111;
        @(negedge clk);
        bus.EVT_VALID = 1'b0; bus.CLR_DROP = 1'b0;
        chk("drop_set_wins", 32'(bus.EVT_DROP), 1);
        drain();
        chk("viol_word_count", 32'(n_words - w0), 7);

        // FIFO full with ACK held off, then release.
        hold = 1'b1;
        w0 = n_words;
        for (int k = 0; k < 5; k++) send_vec(100 + k, 15, 0);
        repeat (10) @(negedge clk);
        chk("full_level", 32'(bus.FIFO_LEVEL), 16);
        chk("full_ready", 32'(bus.EVT_READY), 0);
        chk("full_req", 32'(bus.AEROUT_REQ), 1);
        hold = 1'b0;
        drain();
        chk("full_word_count", 32'(n_words - w0), 20);
        chk("full_level_after", 32'(bus.FIFO_LEVEL), 0);

        // Reset in the middle of a handshake with the drop flag set.
        hold = 1'b1;
        send_vec(50, 15, 0);
        bus.EVT_VALID = 1'b1;
        @(negedge clk);
        bus.EVT_VALID = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_req", 32'(bus.AEROUT_REQ), 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("reset_mid");
        exp_q.delete();
        @(negedge clk);
        hold = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized traffic with random ACK latency.
        rand_dly = 1'b1;
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_vec(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
        end
        drain();
        chk("final_level", 32'(bus.FIFO_LEVEL), 0);
        chk("final_ready", 32'(bus.EVT_READY), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/post_spike_aer_encoder.md
# post_spike_aer_encoder

Downstream stage of the neuron core: consumes the per-group post-synaptic spike vector (`NEUR_EVENT_OUT`, one bit per parallel neuron) and serialises the set bits into individual neuron addresses. Addresses are buffered in an output FIFO and sent off-core through a four-phase AER req/ack handshake. It exerts backpressure on the controller through `EVT_READY`, so no spike is lost while the FIFO is full.

## Interface
- `POST_NEUR_PARALLEL`, 4: spike bits per event vector; power of two.
- `POST_NEUR_ADDR_WIDTH`, 10: post-neuron address width.
- `AER_WIDTH`, 12: AER output word width; must be ≥ `POST_NEUR_ADDR_WIDTH`.
- `TIME_STEP`, 8: time steps per sample; `TS_W` = clog2(`TIME_STEP`).
- `FIFO_DEPTH`, 16: output FIFO entries; power of two.
- `GRP_W` (local): `POST_NEUR_ADDR_WIDTH` − clog2(`POST_NEUR_PARALLEL`).

Ports:
- `CLK` in 1: single clock; all logic is rising-edge.
- `RST_N` in 1: reset, asynchronous and active-low.
- `NEUR_EVENT_OUT` in `POST_NEUR_PARALLEL`: spike vector from the neuron core.
- `EVT_VALID` in 1: vector, group and time step are valid this cycle.
- `EVT_GROUP_ADDR` in `GRP_W`: post-neuron SRAM word address of the vector.
- `CURRENT_TIME_STEP` in `TS_W`: time step of the vector.
- `EVT_READY` out 1: the block can accept a vector.
- `CLR_DROP` in 1: clears `EVT_DROP`.
- `EVT_DROP` out 1: sticky protocol-violation flag.
- `FIFO_LEVEL` out clog2(`FIFO_DEPTH`)+1: current FIFO occupancy.
- `AEROUT_ADDR` out `AER_WIDTH`: neuron address, zero-extended.
- `AEROUT_REQ` out 1: AER request.
- `AEROUT_ACK` in 1: AER acknowledge; asynchronous.

## Operation
- **Capture.** On `EVT_VALID && EVT_READY`, latch the vector into `pend_mask`, plus the group and time step. An all-zero vector is accepted and produces nothing.
- **Ready.** `EVT_READY` = (`pend_mask` == 0), decoded combinationally from a register.
- **Violation.** `EVT_VALID && !EVT_READY` ignores the vector and sets `EVT_DROP`. `CLR_DROP` clears it. If set and clear occur in the same cycle, set wins.
- **Serialiser.** Each cycle with `pend_mask` ≠ 0 and the FIFO not full:
  - take the lowest set bit `i`;
  - push {group, `i`} (plus time step under the macro);
  - clear bit `i`.
  - Result: one push per cycle, ascending neuron order.
- **Full FIFO.** The full test uses the pre-edge count. A push is blocked even if a pop occurs on the same edge. `pend_mask` holds; nothing is dropped.
- **Output FSM.**
  - IDLE: if the FIFO is non-empty, load the head into `AEROUT_ADDR` and go to REQ, with `AEROUT_REQ`=1.
  - REQ: when `ack_s`=1, pop, drop `AEROUT_REQ` and go to ACKLO.
  - ACKLO: when `ack_s`=0, go to IDLE.
- **ACK synchroniser.** `AEROUT_ACK` passes through a 2-flop synchroniser (`ack_s`).
- **Address range.** `AEROUT_ADDR` holds its value until the next load. Addresses for `GRP_W` groups need no wrap logic.
- **FIFO pointers.** Pointers wrap modulo `FIFO_DEPTH`. `FIFO_LEVEL` = pushes − pops and stays in 0..`FIFO_DEPTH`.

## Timing
- **Reset values:**
  - `EVT_READY`=1, `EVT_DROP`=0, `FIFO_LEVEL`=0;
  - `AEROUT_REQ`=0, `AEROUT_ADDR`=0;
  - FSM in IDLE, `pend_mask`=0, synchroniser flops 0.
- **Capture to ready.** Capture at edge N. With k set bits and no stall, pushes occur at edges N+1..N+k, and `EVT_READY` is high after edge N+k.
- **First request.** With the FIFO empty and the FSM in IDLE, `AEROUT_REQ` rises after edge N+2.
- **ACK latency.** ACK rising is seen 2 edges later; `AEROUT_REQ` falls at the 3rd edge after ACK rises. ACK falling is seen similarly; IDLE is reached 3 edges after ACK falls. The next `AEROUT_REQ` comes one edge after that.
- **Reset mid-handshake.** Asserting reset mid-handshake forces reset values immediately. The FIFO contents are discarded.

## Configuration
- `AER_TSTEP_TAG_EN` defined:
  - FIFO entries carry `CURRENT_TIME_STEP`.
  - `AEROUT_ADDR` = {`TS_W` time-step bits, neuron address}, zero-extended to `AER_WIDTH`.
  - Elaboration error if `TS_W` + `POST_NEUR_ADDR_WIDTH` > `AER_WIDTH`; the defaults then require `AER_WIDTH`=13.
- `AER_TSTEP_TAG_EN` undefined: no time-step storage, and `CURRENT_TIME_STEP` is unused.

## Test plan
- **Reset:** pulse `RST_N` low mid-run → `EVT_READY`=1, `AEROUT_REQ`=0, `AEROUT_ADDR`=0, `FIFO_LEVEL`=0, `EVT_DROP`=0.
- **Sparse vector:** group 5, vector 4'b1010, ACK driven 2 cycles after REQ → words 21 then 23; `EVT_READY` low for exactly 2 cycles after capture.
- **Back-to-back groups:** group 0 = 4'b1111, then group 63 = 4'b1001 at the earliest ready → words 0,1,2,3,252,255 in order.
- **FIFO full:** hold ACK low and inject five 4'b1111 vectors → `FIFO_LEVEL`=16, `EVT_READY` stays low; then toggle ACK → 20 words, none lost or duplicated.
- **Violation:** `EVT_VALID` while `EVT_READY`=0 → `EVT_DROP`=1 and no extra words; `CLR_DROP` pulse → 0; `CLR_DROP` together with a new violation → remains 1.
- **Macro:** with `AER_TSTEP_TAG_EN` and `AER_WIDTH`=13, step 6, group 2, bit 3 → `AEROUT_ADDR` = {3'd6, 10'd11}.
